// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the tileram arbiter.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SLOT,
    ACCESS,
    DONE
  } arb_state_t;

  // Horizontal phases the tile fetch never uses; CPU may borrow them.
  localparam logic [3:0] CPU_SLOT_PH0 = 4'h4;
  localparam logic [3:0] CPU_SLOT_PH1 = 4'h5;

endpackage

// File: rtl/vram_slot_decode.sv
// Free-slot decode for CPU tileram access.
// Macro VRAM_CPU_SLOT_EN adds two idle fetch phases per 16 as slots during active video.
module vram_slot_decode
  import vram_arb_pkg::*;
(
  input  logic [9:0] htiming,
  input  logic       cmpblk,
  output logic       slot
);

`ifdef VRAM_CPU_SLOT_EN
  logic [5:0] unused_htiming_hi;
  assign unused_htiming_hi = htiming[9:4];
  assign slot = cmpblk
              | (htiming[3:0] == CPU_SLOT_PH0)
              | (htiming[3:0] == CPU_SLOT_PH1);
`else
  logic [9:0] unused_htiming;
  assign unused_htiming = htiming;
  assign slot = cmpblk;
`endif

endmodule

// File: rtl/vram_arbiter.sv
// Single-port tileram arbiter: video fetch owns the RAM, the Z80 is stalled until a free slot.
// Optional macro VRAM_CPU_SLOT_EN (see vram_slot_decode) enables extra slots in active video.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int AW       = 10,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 1023,
  parameter int WCW      = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    htiming,
  input  logic          cmpblk,
  input  logic [AW-1:0] video_addr,
  input  logic          cpu_sel,
  input  logic          cpu_rd_n,
  input  logic          cpu_wr_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_wait_n,
  input  logic [DW-1:0] ram_dout,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_ena,
  output logic          ram_wr,
  output logic          cpu_owner,
  output logic          starve
);

  localparam logic [WCW-1:0] CNT_MAX    = '1;
  localparam logic [WCW-1:0] MAX_WAIT_W = WCW'(MAX_WAIT);

  arb_state_t     state, state_next;
  logic           req, is_wr, slot;
  logic [WCW-1:0] wait_cnt, wait_inc;
  logic           rd_fresh;
  logic [DW-1:0]  dout_q;

  assign req   = cpu_sel & (~cpu_rd_n | ~cpu_wr_n);
  assign is_wr = ~cpu_wr_n;

  vram_slot_decode u_slot_decode (
    .htiming (htiming),
    .cmpblk  (cmpblk),
    .slot    (slot)
  );

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (req) state_next = slot ? ACCESS : WAIT_SLOT;
      WAIT_SLOT: if (!req) state_next = IDLE;
                 else if (slot) state_next = ACCESS;
      ACCESS:    state_next = DONE;
      DONE:      if (!req) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // NOTE: outputs are gated by rst so a write caught mid-ACCESS never reaches the RAM.
  always_comb begin
    cpu_owner  = (state == ACCESS) & ~rst;
    ram_addr   = cpu_owner ? cpu_addr : video_addr;
    ram_din    = cpu_din;
    ram_ena    = 1'b1;
    ram_wr     = cpu_owner & is_wr;
    cpu_wait_n = rst | ~(req & (state != DONE));
    cpu_dout   = (rd_fresh & ~rst) ? ram_dout : dout_q;
  end

  assign wait_inc = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else begin
      unique case (state)
        WAIT_SLOT: begin
          wait_cnt <= wait_inc;
          if (wait_inc >= MAX_WAIT_W) starve <= 1'b1;
        end
        IDLE:    wait_cnt <= '0;
        DONE:    if (!req) wait_cnt <= '0;
        default: wait_cnt <= wait_cnt;
      endcase
    end
  end

  // RAM data arrives in the first DONE cycle; pass it through, then hold the captured copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_fresh <= 1'b0;
      dout_q   <= '0;
    end else begin
      rd_fresh <= (state == ACCESS) & ~is_wr;
      if (rd_fresh) dout_q <= ram_dout;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: RAM model, write/read scoreboards, per-scenario tasks.
module tb_vram_arbiter;
  import vram_arb_pkg::*;

  localparam int AW = 10;
  localparam int DW = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xact_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    htiming = '0;
  logic          cmpblk;
  logic [AW-1:0] video_addr;
  logic          cpu_sel, cpu_rd_n, cpu_wr_n;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic [DW-1:0] cpu_dout;
  logic          cpu_wait_n;
  logic [DW-1:0] ram_dout;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_ena, ram_wr, cpu_owner, starve;

  logic [DW-1:0] mem [1024];
  logic [DW-1:0] ram_q;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  xact_t         wr_q[$];
  logic [DW-1:0] rd_q[$];
  xact_t         mon_e;
  int            wr_pulses = 0;
  int            last_wr_cyc = -1;
  int            owner_cycles = 0;
  int            owner_late = 0;
  logic [9:0]    last_owner_ht = '0;

  vram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(8), .WCW(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .htiming    (htiming),
    .cmpblk     (cmpblk),
    .video_addr (video_addr),
    .cpu_sel    (cpu_sel),
    .cpu_rd_n   (cpu_rd_n),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .cpu_wait_n (cpu_wait_n),
    .ram_dout   (ram_dout),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_ena    (ram_ena),
    .ram_wr     (ram_wr),
    .cpu_owner  (cpu_owner),
    .starve     (starve)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    htiming <= htiming + 10'd1;
  end

  // Video fetch walks 0x300-0x37F, a region that never holds 8'hA5.
  assign video_addr = 10'h300 | {3'b000, htiming[6:0]};

  always @(posedge clk) begin
    if (ram_ena) begin
      if (ram_wr) mem[ram_addr] <= ram_din;
      ram_q <= mem[ram_addr];
    end
  end
  assign ram_dout = ram_q;

  // Write scoreboard and bus-ownership monitor.
  always @(negedge clk) begin
    if (cpu_owner) begin
      owner_cycles++;
      last_owner_ht = htiming;
      if (!cmpblk && htiming[3:0] >= 4'hC) owner_late++;
    end
    if (ram_wr) begin
      wr_pulses++;
      last_wr_cyc = cyc;
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%h data=%h, none expected", ram_addr, ram_din);
      end else begin
        mon_e = wr_q.pop_front();
        if (ram_addr !== mon_e.addr || ram_din !== mon_e.data) begin
          errors++;
          $display("FAIL write_xact: got %h<=%h, expected %h<=%h",
                   ram_addr, ram_din, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic drive_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_sel  = 1'b1;
    cpu_addr = a;
    cpu_din  = d;
    cpu_wr_n = ~we;
    cpu_rd_n = we;
  endtask

  task automatic release_req();
    cpu_sel  = 1'b0;
    cpu_rd_n = 1'b1;
    cpu_wr_n = 1'b1;
  endtask

  task automatic wait_ready(input int bound, output int lows);
    bit done;
    lows = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (cpu_wait_n) begin
        done = 1;
      end else begin
        lows++;
        if (lows > bound) begin
          checks++;
          errors++;
          $display("FAIL wait_timeout: cpu_wait_n low for %0d cycles, limit %0d", lows, bound);
          done = 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmpblk = 1'b0;
    release_req();
    cpu_addr = '0;
    cpu_din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (cpu_dout !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h, expected 00", cpu_dout); end
    checks++; if (cpu_wait_n !== 1'b1) begin errors++; $display("FAIL rst_wait_n: got %b, expected 1", cpu_wait_n); end
    checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL rst_ram_wr: got %b, expected 0", ram_wr); end
    checks++; if (cpu_owner !== 1'b0) begin errors++; $display("FAIL rst_owner: got %b, expected 0", cpu_owner); end
    checks++; if (starve !== 1'b0) begin errors++; $display("FAIL rst_starve: got %b, expected 0", starve); end
    checks++; if (ram_ena !== 1'b1) begin errors++; $display("FAIL rst_ram_ena: got %b, expected 1", ram_ena); end
    checks++; if (ram_addr !== video_addr) begin errors++; $display("FAIL rst_ram_addr: got %h, expected %h", ram_addr, video_addr); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_read_blank();
    logic [DW-1:0] e;
    @(posedge clk); #1;
    cmpblk = 1'b1;
    @(posedge clk); #1;
    drive_req(1'b0, 10'h040, 8'h00);
    rd_q.push_back(8'hA5);
    @(negedge clk);
    checks++; if (cpu_wait_n !== 1'b0) begin errors++; $display("FAIL rd_wait_same_cycle: got %b, expected 0", cpu_wait_n); end
    @(negedge clk);
    checks++; if (cpu_owner !== 1'b1 || ram_addr !== 10'h040 || ram_wr !== 1'b0) begin
      errors++; $display("FAIL rd_access_t1: owner=%b addr=%h wr=%b, expected 1/040/0", cpu_owner, ram_addr, ram_wr);
    end
    @(negedge clk);
    checks++; if (cpu_wait_n !== 1'b1) begin errors++; $display("FAIL rd_ready_t2: got %b, expected 1", cpu_wait_n); end
    e = rd_q.pop_front();
    checks++; if (cpu_dout !== e) begin errors++; $display("FAIL rd_data_t2: got %h, expected %h", cpu_dout, e); end
    @(negedge clk);
    checks++; if (cpu_dout !== e) begin errors++; $display("FAIL rd_data_hold: got %h, expected %h", cpu_dout, e); end
    @(posedge clk); #1;
    release_req();
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int owners0, pulses0;
    cmpblk = 1'b0;
    do begin @(posedge clk); #1; end while (htiming[3:0] != 4'h8);
    owners0 = owner_cycles;
    pulses0 = wr_pulses;
    drive_req(1'b1, 10'h155, 8'h99);
    repeat (3) @(negedge clk);
    checks++; if (cpu_wait_n !== 1'b0) begin errors++; $display("FAIL abort_waiting: got %b, expected 0", cpu_wait_n); end
    @(posedge clk); #1;
    release_req();
    @(negedge clk);
    checks++; if (cpu_wait_n !== 1'b1) begin errors++; $display("FAIL abort_wait_n: got %b, expected 1", cpu_wait_n); end
    @(negedge clk);
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL abort_state: got %0d, expected %0d", dut.state, IDLE); end
    checks++; if (owner_cycles !== owners0 || wr_pulses !== pulses0) begin
      errors++; $display("FAIL abort_no_access: owner cycles %0d writes %0d, expected %0d/%0d",
                         owner_cycles, wr_pulses, owners0, pulses0);
    end
  endtask

`ifndef VRAM_CPU_SLOT_EN
  task automatic test_write_active();
    int lows, lows2, pulses0, rise_cyc;
    logic s6, s12;
    xact_t x;
    @(posedge clk); #1;
    cmpblk = 1'b0;
    pulses0 = wr_pulses;
    x.addr = 10'h1FF;
    x.data = 8'h3C;
    drive_req(1'b1, x.addr, x.data);
    wr_q.push_back(x);
    lows = 0;
    s6 = 1'bx;
    s12 = 1'bx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!cpu_wait_n) lows++;
      if (i == 6) s6 = starve;
      if (i == 12) s12 = starve;
    end
    checks++; if (lows !== 40) begin errors++; $display("FAIL wr_stall_cycles: got %0d, expected 40", lows); end
    checks++; if (wr_pulses !== pulses0) begin errors++; $display("FAIL wr_during_video: got %0d pulses, expected 0", wr_pulses - pulses0); end
    checks++; if (s6 !== 1'b0) begin errors++; $display("FAIL starve_early: got %b, expected 0", s6); end
    checks++; if (s12 !== 1'b1) begin errors++; $display("FAIL starve_set: got %b, expected 1", s12); end
    @(posedge clk); #1;
    cmpblk = 1'b1;
    rise_cyc = cyc;
    wait_ready(8, lows2);
    checks++; if (lows2 !== 2) begin errors++; $display("FAIL wr_grant_latency: got %0d, expected 2", lows2); end
    checks++; if (wr_pulses !== pulses0 + 1) begin errors++; $display("FAIL wr_pulse_count: got %0d, expected 1", wr_pulses - pulses0); end
    checks++; if (last_wr_cyc !== rise_cyc + 1) begin errors++; $display("FAIL wr_pulse_cycle: got %0d, expected %0d", last_wr_cyc, rise_cyc + 1); end
    checks++; if (starve !== 1'b1) begin errors++; $display("FAIL starve_sticky: got %b, expected 1", starve); end
    @(posedge clk); #1;
    release_req();
    @(posedge clk); #1;
  endtask
`else
  task automatic test_slot_phase();
    int lows, late0;
    logic [9:0] req_ht;
    logic [5:0] exp_grp;
    xact_t x;
    cmpblk = 1'b0;
    do begin @(posedge clk); #1; end while (htiming[3:0] != 4'h8);
    req_ht = htiming;
    exp_grp = req_ht[9:4] + 6'd1;
    late0 = owner_late;
    x.addr = 10'h1FF;
    x.data = 8'h3C;
    drive_req(1'b1, x.addr, x.data);
    wr_q.push_back(x);
    wait_ready(40, lows);
    checks++; if (last_owner_ht[3:0] != CPU_SLOT_PH0 && last_owner_ht[3:0] != CPU_SLOT_PH1) begin
      errors++; $display("FAIL slot_phase: got %h, expected 4 or 5", last_owner_ht[3:0]);
    end
    checks++; if (last_owner_ht[9:4] !== exp_grp) begin errors++; $display("FAIL slot_group: got %h, expected %h", last_owner_ht[9:4], exp_grp); end
    checks++; if (owner_late !== late0) begin errors++; $display("FAIL slot_late_phase: got %0d, expected 0", owner_late - late0); end
    @(posedge clk); #1;
    release_req();
    @(posedge clk); #1;
    cmpblk = 1'b1;
  endtask
`endif

  task automatic test_readback();
    int lows;
    logic [DW-1:0] e;
    @(posedge clk); #1;
    cmpblk = 1'b1;
    drive_req(1'b0, 10'h1FF, 8'h00);
    rd_q.push_back(8'h3C);
    wait_ready(6, lows);
    checks++; if (lows !== 2) begin errors++; $display("FAIL readback_latency: got %0d, expected 2", lows); end
    e = rd_q.pop_front();
    checks++; if (cpu_dout !== e) begin errors++; $display("FAIL readback_data: got %h, expected %h", cpu_dout, e); end
    @(posedge clk); #1;
    release_req();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_access();
    logic [DW-1:0] m0;
    m0 = mem[10'h2AA];
    cmpblk = 1'b1;
    drive_req(1'b1, 10'h2AA, 8'h77);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL rstacc_ram_wr: got %b, expected 0", ram_wr); end
    checks++; if (cpu_wait_n !== 1'b1) begin errors++; $display("FAIL rstacc_wait_n: got %b, expected 1", cpu_wait_n); end
    @(posedge clk); #1;
    rst = 1'b0;
    release_req();
    @(negedge clk);
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rstacc_state: got %0d, expected %0d", dut.state, IDLE); end
    checks++; if (cpu_dout !== 8'h00) begin errors++; $display("FAIL rstacc_dout: got %h, expected 00", cpu_dout); end
    checks++; if (cpu_wait_n !== 1'b1) begin errors++; $display("FAIL rstacc_idle_wait_n: got %b, expected 1", cpu_wait_n); end
    checks++; if (starve !== 1'b0) begin errors++; $display("FAIL rstacc_starve: got %b, expected 0", starve); end
    checks++; if (mem[10'h2AA] !== m0) begin errors++; $display("FAIL rstacc_mem: got %h, expected %h", mem[10'h2AA], m0); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[10'h040] = 8'hA5;
    test_reset();
    test_read_blank();
    test_abort();
`ifndef VRAM_CPU_SLOT_EN
    test_write_active();
`else
    test_slot_phase();
`endif
    test_readback();
    test_reset_access();
    checks++; if (wr_q.size() != 0 || rd_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d writes %0d reads left, expected 0/0", wr_q.size(), rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
